// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: MUL_LAT-cycle multiply, radix-2 restoring divide plus sign fix-up.
// Optional macro MDU_DIV_ZERO_FAST_EN: divide-by-zero completes right after accept instead of iterating.
module mdu_iter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             op_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] MulLast = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DivLast = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic             sign_q, zero_q, neg_quo_q, neg_rem_q;
    logic             out_valid_q, div_zero_q;
    logic [WIDTH-1:0] srca_q, srcb_q, quo_q, rem_q, hi_q, lo_q;

    logic             accept, done, srcb_zero, fits;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0] bmag;
    logic [WIDTH:0]   rem_sh, diff;

    assign accept    = in_valid & ~busy & ~flush;
    assign srcb_zero = (srcb == '0);
    // A flush in the last working cycle still cancels the completion.
    assign done      = ~flush & (((state_q == StMul) && (cnt_q == MulLast)) || (state_q == StFix));

    assign ext_a = sign_q ? {{WIDTH{srca_q[WIDTH-1]}}, srca_q} : {{WIDTH{1'b0}}, srca_q};
    assign ext_b = sign_q ? {{WIDTH{srcb_q[WIDTH-1]}}, srcb_q} : {{WIDTH{1'b0}}, srcb_q};
    assign prod  = ext_a * ext_b;

    assign bmag   = (sign_q & srcb_q[WIDTH-1]) ? -srcb_q : srcb_q;
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, bmag};
    assign fits   = ~diff[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!op_div) begin
                        state_d = StMul;
                    end else begin
`ifdef MDU_DIV_ZERO_FAST_EN
                        state_d = srcb_zero ? StFix : StDiv;
`else
                        state_d = StDiv;
`endif
                    end
                end
            end
            StMul:   if (flush || cnt_q == MulLast) state_d = StIdle;
            StDiv:   if (flush) state_d = StIdle; else if (cnt_q == DivLast) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // The completion cycle itself still reports busy.
        busy = (state_q != StIdle) | out_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            srca_q      <= '0;
            srcb_q      <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            out_valid_q <= done;
            if (accept) begin
                cnt_q     <= '0;
                sign_q    <= sign;
                zero_q    <= srcb_zero;
                neg_quo_q <= sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                neg_rem_q <= sign & srca[WIDTH-1];
                srca_q    <= srca;
                srcb_q    <= srcb;
                quo_q     <= (sign & srca[WIDTH-1]) ? -srca : srca;
                rem_q     <= '0;
            end else if (state_q == StMul || state_q == StDiv) begin
                cnt_q <= cnt_q + CW'(1);
                if (state_q == StDiv) begin
                    rem_q <= fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], fits};
                end
            end
            if (done) begin
                if (state_q == StMul) begin
                    {hi_q, lo_q} <= prod;
                    div_zero_q   <= 1'b0;
                end else if (zero_q) begin
                    hi_q       <= srca_q;
                    lo_q       <= '1;
                    div_zero_q <= 1'b1;
                end else begin
                    hi_q       <= neg_rem_q ? -rem_q : rem_q;
                    lo_q       <= neg_quo_q ? -quo_q : quo_q;
                    div_zero_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: driver pushes model results, a negedge monitor pops and compares.
module tb_mdu_iter;

    localparam int W  = 32;
    localparam int ML = 2;

    logic         clk = 1'b0;
    logic         rst, in_valid, op_div, sign, flush;
    logic [W-1:0] srca, srcb;
    logic         busy, out_valid, div_zero;
    logic [W-1:0] hi, lo;

    mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op_div    (op_div),
        .sign      (sign),
        .srca      (srca),
        .srcb      (srcb),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .hi        (hi),
        .lo        (lo),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] last_hi = '0, last_lo = '0;
    logic         last_dz = 1'b0;
    bit           mon_en  = 1'b0;
    int           n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic void model(input logic od, input logic s, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] h,
                                  output logic [31:0] l, output logic dz);
        longint p;
        int sa, sb;
        dz = 1'b0;
        if (!od) begin
            if (s) p = longint'($signed(a)) * longint'($signed(b));
            else   p = longint'({32'b0, a}) * longint'({32'b0, b});
            {h, l} = p;
        end else if (b == 0) begin
            h = a; l = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                l = a; h = 0;
            end else begin
                sa = a; sb = b;
                l = sa / sb; h = sa % sb;
            end
        end else begin
            l = a / b; h = a % b;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result_hi", hi, e.hi);
                    chk("result_lo", lo, e.lo);
                    chk("result_div_zero", div_zero, e.dz);
                    chk("result_cycle", cyc, e.cyc);
                    last_hi = e.hi; last_lo = e.lo; last_dz = e.dz;
                end
            end else begin
                chk("hold_hi", hi, last_hi);
                chk("hold_lo", lo, last_lo);
                chk("hold_div_zero", div_zero, last_dz);
                if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                    chk("late_out_valid", cyc, sbq[0].cyc);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic od, input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   waited = 0;
        int   lat;
        @(negedge clk);
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            chk("busy_timeout", busy, 1'b0);
            return;
        end
        model(od, s, a, b, e.hi, e.lo, e.dz);
        in_valid = 1'b1; op_div = od; sign = s; srca = a; srcb = b;
        @(posedge clk);
        #1;
        lat = od ? W + 1 : ML;
`ifdef MDU_DIV_ZERO_FAST_EN
        if (od && b == 0) lat = 1;
`endif
        e.cyc = cyc + lat;
        sbq.push_back(e);
        in_valid = 1'b0; op_div = $urandom_range(0, 1); sign = $urandom_range(0, 1);
        srca = $urandom; srcb = $urandom;
        chk("busy_after_accept", busy, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_div = 1'b0; sign = 1'b0; flush = 1'b0;
        srca = '0; srcb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_div_zero", div_zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        issue(1, 1, 32'hFFFF_FFF9, 32'd2);
        issue(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Busy handshake: a held request with changing operands must be ignored.
        issue(1, 0, 32'd1000, 32'd7);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            srca = $urandom; srcb = $urandom; op_div = $urandom_range(0, 1);
            chk("busy_hold", busy, 1'b1);
        end
        in_valid = 1'b0;
        issue(0, 0, 32'd12345, 32'd678);
        drain();

        // Flush at iteration 10 of a divide.
        issue(1, 0, 32'd10, 32'd3);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(sbq.pop_back());
        chk("flush_busy", busy, 1'b0);
        chk("flush_hi", hi, last_hi);
        chk("flush_lo", lo, last_lo);
        repeat (40) @(negedge clk);
        issue(1, 0, 32'd10, 32'd3);
        drain();

        // Request together with flush is not accepted.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op_div = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_with_request_busy", busy, 1'b0);
        repeat (5) @(negedge clk);

        issue(1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1, 0, 32'd5, 32'd0);
        issue(1, 1, 32'hFFFF_FFF0, 32'd0);
        drain();

        // Reset in the middle of a multiply.
        issue(0, 1, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        void'(sbq.pop_back());
        last_hi = '0; last_lo = '0; last_dz = 1'b0;
        chk("midop_reset_busy", busy, 1'b0);
        chk("midop_reset_out_valid", out_valid, 1'b0);
        chk("midop_reset_hi", hi, 32'h0);
        chk("midop_reset_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = 32'h8000_0000;
                3: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
                default: ;
            endcase
            issue($urandom_range(0, 1), $urandom_range(0, 1), a, b);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
